// File: rtl/bram_rd_stream_if.sv
// Command, memory read-port and stream signals of bram_rd_stream.
// The streamer takes the slave view; the surrounding system (or bench) takes the master view.
interface bram_rd_stream_if #(
    parameter int unsigned mem_width = 32,
    parameter int unsigned mem_depth = 4096
);
    localparam int unsigned AW = $clog2(mem_depth);

    logic                 s_cmd_valid;
    logic                 s_cmd_ready;
    logic [AW-1:0]        s_cmd_addr;
    logic [AW-1:0]        s_cmd_len;

    logic                 mem_en;
    logic                 mem_wen;
    logic [AW-1:0]        mem_addr;
    logic [mem_width-1:0] mem_din;
    logic [mem_width-1:0] mem_dout;

    logic [mem_width-1:0] m_axis_data;
    logic                 m_axis_valid;
    logic                 m_axis_ready;
    logic                 m_axis_last;

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_len, mem_dout, m_axis_ready,
        output s_cmd_ready, mem_en, mem_wen, mem_addr, mem_din,
               m_axis_data, m_axis_valid, m_axis_last
    );

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_len, mem_dout, m_axis_ready,
        input  s_cmd_ready, mem_en, mem_wen, mem_addr, mem_din,
               m_axis_data, m_axis_valid, m_axis_last
    );
endinterface

// File: rtl/bram_rd_stream.sv
// Reads a burst of consecutive BRAM words and streams them out, flow-controlled by a
// credit counter so that every word read lands in a 4-entry output FIFO.
module bram_rd_stream #(
    parameter string       style            = "HIGH_PERFORMANCE",
    parameter int unsigned mem_width        = 32,
    parameter int unsigned mem_depth        = 4096,
    parameter int          simulation_delay = 1
) (
    input  logic            clk,
    input  logic            rst,
    bram_rd_stream_if.slave bus,
    output logic            busy
);
    localparam int unsigned AW        = $clog2(mem_depth);
    localparam int unsigned Lat       = (style == "LOW_LATENCY") ? 1 : 2;
    localparam int unsigned FifoDepth = 4;

    if (mem_depth < 2 || (mem_depth & (mem_depth - 1)) != 0 || simulation_delay < 0 ||
        !(style == "LOW_LATENCY" || style == "HIGH_PERFORMANCE")) begin : g_bad_param
        $error("bram_rd_stream: illegal parameter (style, power-of-two mem_depth)");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        start_q, start_d;
    logic [AW-1:0]        len_q, len_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [2:0]           credit_q, credit_d;
    logic [Lat-1:0]       pipe_vld_q, pipe_last_q;
    logic [mem_width-1:0] fifo_data_q [FifoDepth];
    logic [FifoDepth-1:0] fifo_last_q;
    logic [1:0]           wptr_q, rptr_q;
    logic [2:0]           count_q;

    logic issue, issue_last, push, push_last, pop, fifo_nonempty;

    assign fifo_nonempty = (count_q != 3'd0);
    assign pop           = fifo_nonempty & bus.m_axis_ready;
    assign push          = pipe_vld_q[Lat-1];
    assign push_last     = pipe_last_q[Lat-1];
    assign issue_last    = issue & (idx_q == len_q);

    always_comb begin
        state_d         = state_q;
        start_d         = start_q;
        len_d           = len_q;
        idx_d           = idx_q;
        issue           = 1'b0;
        bus.s_cmd_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.s_cmd_ready = 1'b1;
                if (bus.s_cmd_valid) begin
                    start_d = bus.s_cmd_addr;
                    len_d   = bus.s_cmd_len;
                    idx_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Only read when a FIFO slot is guaranteed for the returning word.
                issue = (credit_q != 3'd0);
                if (issue) begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == len_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && bus.m_axis_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address arithmetic wraps naturally at mem_depth since AW = log2(mem_depth).
    assign bus.mem_en   = issue;
    assign bus.mem_addr = start_q + idx_q;
    assign bus.mem_wen  = 1'b0;
    assign bus.mem_din  = '0;

    assign credit_d = credit_q - {2'b00, issue} + {2'b00, pop};

    assign bus.m_axis_valid = fifo_nonempty;
    assign bus.m_axis_data  = fifo_data_q[rptr_q];
    assign bus.m_axis_last  = fifo_last_q[rptr_q] & fifo_nonempty;
    assign busy             = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            start_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            credit_q    <= 3'(FifoDepth);
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            fifo_last_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            credit_q       <= credit_d;
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < Lat; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            if (push) begin
                fifo_last_q[wptr_q] <= push_last;
                wptr_q              <= wptr_q + 2'd1;
            end
            if (pop) rptr_q <= rptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_data_q[wptr_q] <= bus.mem_dout;
    end
endmodule

// File: tb/tb_bram_rd_stream.sv
// Bench for bram_rd_stream: one instance per read latency, a behavioural BRAM and a
// queue-based model of the expected address and data sequence of each burst.
module tb_bram_rd_stream;
    localparam int unsigned MemWidth = 32;
    localparam int unsigned MemDepth = 4096;
    localparam int unsigned AW       = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_rd_stream_if #(.mem_width(MemWidth), .mem_depth(MemDepth)) hp_if ();
    bram_rd_stream_if #(.mem_width(MemWidth), .mem_depth(MemDepth)) ll_if ();
    logic hp_busy, ll_busy;

    bram_rd_stream #(
        .style("HIGH_PERFORMANCE"), .mem_width(MemWidth), .mem_depth(MemDepth),
        .simulation_delay(1)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(hp_if.slave), .busy(hp_busy)
    );

    bram_rd_stream #(
        .style("LOW_LATENCY"), .mem_width(MemWidth), .mem_depth(MemDepth),
        .simulation_delay(1)
    ) u_dut_ll (
        .clk(clk), .rst(rst), .bus(ll_if.slave), .busy(ll_busy)
    );

    logic [1:0]    cmd_valid;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          axis_ready;

    assign hp_if.s_cmd_valid  = cmd_valid[0];
    assign ll_if.s_cmd_valid  = cmd_valid[1];
    assign hp_if.s_cmd_addr   = cmd_addr;
    assign ll_if.s_cmd_addr   = cmd_addr;
    assign hp_if.s_cmd_len    = cmd_len;
    assign ll_if.s_cmd_len    = cmd_len;
    assign hp_if.m_axis_ready = axis_ready;
    assign ll_if.m_axis_ready = axis_ready;

    // BRAM: data appears 2 (hp) or 1 (ll) clocks after mem_en; junk otherwise.
    logic [MemWidth-1:0] mem [MemDepth];
    logic [MemWidth-1:0] hp_r1, hp_r2, ll_r1;
    always @(posedge clk) begin
        hp_r1 <= hp_if.mem_en ? mem[hp_if.mem_addr] : 32'hDEAD_BEEF;
        hp_r2 <= hp_r1;
        ll_r1 <= ll_if.mem_en ? mem[ll_if.mem_addr] : 32'hDEAD_BEEF;
    end
    assign hp_if.mem_dout = hp_r2;
    assign ll_if.mem_dout = ll_r1;

    int                  sel;
    logic                o_cmd_ready, o_mem_en, o_valid, o_last, o_busy, o_wen;
    logic [AW-1:0]       o_mem_addr;
    logic [MemWidth-1:0] o_data, o_din;
    always_comb begin
        o_cmd_ready = hp_if.s_cmd_ready;
        o_mem_en    = hp_if.mem_en;
        o_mem_addr  = hp_if.mem_addr;
        o_valid     = hp_if.m_axis_valid;
        o_last      = hp_if.m_axis_last;
        o_data      = hp_if.m_axis_data;
        o_busy      = hp_busy;
        o_wen       = hp_if.mem_wen;
        o_din       = hp_if.mem_din;
        if (sel == 1) begin
            o_cmd_ready = ll_if.s_cmd_ready;
            o_mem_en    = ll_if.mem_en;
            o_mem_addr  = ll_if.mem_addr;
            o_valid     = ll_if.m_axis_valid;
            o_last      = ll_if.m_axis_last;
            o_data      = ll_if.m_axis_data;
            o_busy      = ll_busy;
            o_wen       = ll_if.mem_wen;
            o_din       = ll_if.mem_din;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready low in cycles 6..15
    task automatic run_burst(input int s, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                             input int mode, output int first_valid, output int beats,
                             output int lasts, output int span);
        logic [MemWidth-1:0] exp_q[$];
        logic [AW-1:0]       exp_addr[$];
        logic [MemWidth-1:0] prev_data;
        logic                prev_last;
        bit                  prev_stall = 1'b0;
        bit                  done = 1'b0;
        int                  issued = 0, popped = 0, last_pop = -1, cyc = 0, budget;
        sel         = s;
        first_valid = -1;
        beats       = 0;
        lasts       = 0;
        prev_data   = '0;
        prev_last   = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            exp_addr.push_back(AW'((int'(addr) + k) % MemDepth));
            exp_q.push_back(mem[(int'(addr) + k) % MemDepth]);
        end
        budget = 8 * (int'(len) + 1) + 40;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cmd_valid = '0;
            if (cyc == 0) begin
                cmd_addr     = addr;
                cmd_len      = len;
                cmd_valid[s] = 1'b1;
            end
            case (mode)
                1:       axis_ready = 1'($urandom_range(0, 1));
                2:       axis_ready = !(cyc >= 6 && cyc < 16);
                default: axis_ready = 1'b1;
            endcase
            #1;
            if (cyc == 0) check("cmd_ready_idle", o_cmd_ready, 1);
            else          check("busy_no_accept", {o_busy, o_cmd_ready}, 2'b10);
            if (issued > int'(len)) begin
                check("no_mem_en_after_last", o_mem_en, 0);
            end else if (o_mem_en) begin
                check("mem_addr", o_mem_addr, exp_addr[issued]);
                issued++;
            end
            check("outstanding_le_4", (issued - popped) <= 4, 1);
            if (mode == 2 && cyc == 15) begin
                check("stall_fifo_holds_4", issued - popped, 4);
                check("stall_mem_en_off", o_mem_en, 0);
            end
            if (prev_stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_data_last", {o_last, o_data}, {prev_last, prev_data});
            end
            prev_stall = o_valid && !axis_ready;
            prev_data  = o_data;
            prev_last  = o_last;
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (o_valid && axis_ready) begin
                if (popped <= int'(len)) begin
                    check("beat_data", o_data, exp_q[popped]);
                    check("beat_last", o_last, popped == int'(len));
                end
                if (o_last) lasts++;
                beats++;
                last_pop = cyc;
                popped++;
                if (o_last || popped > int'(len)) done = 1'b1;
            end
            cyc++;
        end
        check("burst_done_in_budget", done, 1);
        span = last_pop - first_valid;
        @(negedge clk);
        cmd_valid  = '0;
        axis_ready = 1'b1;
        #1;
        check("idle_after_burst", {o_busy, o_cmd_ready, o_valid}, 3'b010);
    endtask

    typedef struct {
        int            s;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        int            mode;
        int            exp_first;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fv, nb, nl, sp, cnt;
        for (int i = 0; i < int'(MemDepth); i++) mem[i] = MemWidth'(i);

        vecs[0] = '{0, 12'h010, 12'd7,  0, 4};
        vecs[1] = '{0, 12'hFFE, 12'd3,  0, 4};
        vecs[2] = '{1, 12'h123, 12'd0,  0, 3};
        vecs[3] = '{0, 12'h200, 12'd0,  0, 4};
        vecs[4] = '{1, 12'h7F0, 12'd5,  0, 3};
        vecs[5] = '{0, 12'h040, 12'd15, 2, 4};
        vecs[6] = '{1, 12'hFFC, 12'd9,  2, 3};

        rst        = 1'b1;
        cmd_valid  = '0;
        cmd_addr   = '0;
        cmd_len    = '0;
        axis_ready = 1'b1;
        sel        = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("reset_outputs", {o_cmd_ready, o_mem_en, o_valid, o_last, o_busy}, 5'b10000);
            check("write_port_tied", {o_wen, o_din}, '0);
        end
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].s, vecs[v].addr, vecs[v].len, vecs[v].mode, fv, nb, nl, sp);
            if (vecs[v].exp_first >= 0) check("first_valid_cycle", fv, vecs[v].exp_first);
            check("beat_count", nb, int'(vecs[v].len) + 1);
            check("last_count", nl, 1);
            if (vecs[v].mode == 0) check("one_beat_per_clk", sp, int'(vecs[v].len));
        end

        // Reset while beat 3 of an 8-beat burst is being presented.
        sel = 0;
        cnt = 0;
        @(negedge clk);
        cmd_addr   = 12'h300;
        cmd_len    = 12'd7;
        cmd_valid  = 2'b01;
        axis_ready = 1'b1;
        for (int c = 0; c < 30 && cnt < 3; c++) begin
            #1;
            if (o_valid) cnt++;
            @(negedge clk);
            cmd_valid = '0;
        end
        check("rst_burst_progress", cnt, 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midburst_reset_outputs", {o_cmd_ready, o_mem_en, o_valid, o_last, o_busy},
              5'b10000);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            check("no_beat_after_reset", o_valid, 0);
        end
        run_burst(0, 12'h0A0, 12'd1, 0, fv, nb, nl, sp);
        check("post_reset_beats", nb, 2);
        check("post_reset_lasts", nl, 1);

        for (int i = 0; i < 1000; i++) begin
            logic [AW-1:0] a, l;
            a = AW'($urandom_range(0, MemDepth - 1));
            l = AW'($urandom_range(0, 15));
            run_burst(int'($urandom_range(0, 1)), a, l, 1, fv, nb, nl, sp);
            check("rand_beats", nb, int'(l) + 1);
            check("rand_lasts", nl, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bram_rd_stream.md
BRAM_RD_STREAM -- requirements
Module: bram_rd_stream

Interface
REQ-001 SHALL have parameter style, default "HIGH_PERFORMANCE": attached memory read latency; "HIGH_PERFORMANCE" = 2 clk, "LOW_LATENCY" = 1 clk.
REQ-002 SHALL have parameter mem_width, default 32: memory/stream data width in bits.
REQ-003 SHALL have parameter mem_depth, default 4096: memory depth; power of two only; AW = log2(mem_depth).
REQ-004 SHALL have parameter simulation_delay, default 1: simulation delay on register updates; no functional effect.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port s_cmd_valid  input  1  burst command valid.
REQ-008 SHALL have port s_cmd_ready  output  1  burst command ready.
REQ-009 SHALL have port s_cmd_addr  input  AW  burst start address.
REQ-010 SHALL have port s_cmd_len  input  AW  burst length minus one.
REQ-011 SHALL have port mem_en  output  1  memory enable.
REQ-012 SHALL have port mem_wen  output  1  memory write enable; tied 0.
REQ-013 SHALL have port mem_addr  output  AW  memory address.
REQ-014 SHALL have port mem_din  output  mem_width  memory write data; tied 0.
REQ-015 SHALL have port mem_dout  input  mem_width  memory read data, valid L clk after mem_en.
REQ-016 SHALL have port m_axis_data  output  mem_width  stream data.
REQ-017 SHALL have port m_axis_valid  output  1  stream valid.
REQ-018 SHALL have port m_axis_ready  input  1  stream ready.
REQ-019 SHALL have port m_axis_last  output  1  high on final beat of burst.
REQ-020 SHALL have port busy  output  1  high from command accept until last beat handshaked.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-022 SHALL drive s_cmd_ready=1 only in IDLE; handshake = s_cmd_valid & s_cmd_ready; IDLE -> ISSUE on handshake, latching addr and len.
REQ-023 SHALL, in ISSUE, assert mem_en for one cycle per beat when credit > 0, with mem_addr = start + beat index mod mem_depth (wrap 0 after mem_depth-1).
REQ-024 SHALL go ISSUE -> DRAIN in the cycle after the (len+1)-th mem_en; DRAIN -> IDLE on handshake of the beat with m_axis_last=1.
REQ-025 SHALL track in-flight reads with an L-stage valid/last shift pipeline; data captured from mem_dout in the cycle L after its mem_en.
REQ-026 SHALL buffer captured data in a 4-entry FIFO feeding the m_axis port; m_axis_valid = FIFO non-empty; pop on m_axis_valid & m_axis_ready.
REQ-027 SHALL maintain credit = 4 - (in-flight + FIFO occupancy), reset 4; -1 on issue, +1 on pop, both in one cycle = no change; never issue at credit 0, so no capture is ever lost.
REQ-028 SHALL produce first beat m_axis_valid=1 in cycle L+2 after command-accept cycle 0 (first mem_en in cycle 1), given m_axis_ready=1.
REQ-029 SHALL sustain 1 beat/clk with m_axis_ready held 1.
REQ-030 SHALL hold m_axis_data/m_axis_last stable while m_axis_valid=1 and m_axis_ready=0.
REQ-031 SHALL set m_axis_last only on beat index len; len=0 gives a single beat with last=1.
REQ-032 SHALL accept a new command no earlier than the cycle after DRAIN -> IDLE (no overlap between bursts).

Reset
REQ-033 SHALL, on rst, go to IDLE and set s_cmd_ready=1, mem_en=0, m_axis_valid=0, m_axis_last=0, busy=0, credit=4, FIFO empty, pipeline cleared.
REQ-034 SHALL, on rst mid-burst, discard all in-flight and buffered data; no beat emitted after reset for the aborted burst.

Verification
REQ-035 SHALL pass: L=2, memory init mem[i]=i, cmd addr=0x010 len=7, ready=1 -> data 0x10..0x17 on consecutive cycles, first valid in cycle 4, last on 0x17, busy low afterwards.
REQ-036 SHALL pass: cmd addr=0xFFE len=3, depth 4096 -> mem_addr sequence 0xFFE,0xFFF,0x000,0x001; data same.
REQ-037 SHALL pass: ready=0 for 10 cycles mid-burst -> mem_en stops after credit exhausted, FIFO holds 4 beats, no beat lost or duplicated after ready=1.
REQ-038 SHALL pass: len=0, L=1 -> single beat, last=1, valid in cycle 3.
REQ-039 SHALL pass: rst asserted during burst beat 3 of 8 -> outputs at reset values next cycle; new cmd len=1 returns exactly 2 beats.
REQ-040 SHALL pass: random m_axis_ready toggling over 1000 bursts -> scoreboard matches mem contents in order, exactly one last per burst.
